// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline types and constants (skid-buffer state
//                encoding, default datapath width).
//  Revision    : 1.0 - initial release
// ============================================================================

package pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n
//  Description : Combinational N-way binary-select multiplexer; a select
//                value outside 0..NUM_IN-1 yields all zeros.
//  Revision    : 1.0 - initial release
// ============================================================================

module mux_n
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = $clog2(NUM_IN)
)(
    input  logic [NUM_IN-1:0][WIDTH-1:0] d,
    input  logic [SEL_W-1:0]             sel,
    output logic [WIDTH-1:0]             y
);

    // Only in-range codes match a branch, so unused codes fall through to zero.
    always_comb begin
        y = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                y = d[i];
            end
        end
    end

endmodule : mux_n

`default_nettype wire

// File: rtl/mux_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mux_skid_stage
//  Description : N-way operand-select stage registered behind a 2-entry skid
//                buffer with valid/ready flow control and flush.
//                Define MUX_SEL_CHECK_EN to add the sticky sel_err output.
//  Revision    : 1.0 - initial release
// ============================================================================

module mux_skid_stage
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = XLEN,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = $clog2(NUM_IN)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0][WIDTH-1:0] d,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             y,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic                         sel_err
`endif
);

    skid_state_t      r_state;
    skid_state_t      w_next_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main_sel;
    logic             w_load_main_skid;
    logic             w_load_skid;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .d   (d),
        .sel (sel),
        .y   (w_sel_data)
    );

    assign w_accept  = in_valid && r_in_ready && !flush && !reset;
    assign w_pop     = out_valid && out_ready;
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_in_ready;
    assign y         = r_main;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush wins over everything; otherwise the main register always holds
    // the oldest entry and the skid register the younger one.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_sel  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_next_state    = ONE;
                        w_load_main_sel = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_pop) begin
                        w_next_state = FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_accept && w_pop) begin
                        w_next_state    = ONE;
                        w_load_main_sel = 1'b1;
                    end else if (w_pop) begin
                        w_next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_next_state     = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // Ready is registered from the next state so out_ready never reaches
    // in_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_sel) begin
                r_main <= w_sel_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_sel_data;
            end
        end
    end

`ifdef MUX_SEL_CHECK_EN
    localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

    logic r_sel_err;
    logic w_sel_oor;

    assign w_sel_oor = ({1'b0, sel} >= c_num_in);
    assign sel_err   = r_sel_err;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end
`endif

endmodule : mux_skid_stage

`default_nettype wire
